// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN activation path.
// The packer and its output slot take their parameter defaults from here.
package bnn_pkg;

  localparam int BNN_WIDTH       = 32;
  localparam int BNN_LEN_W       = 6;
  localparam int BNN_DEFAULT_LEN = 9;

  typedef logic [BNN_WIDTH-1:0] bnn_word_t;
  typedef logic [BNN_LEN_W-1:0] bnn_cnt_t;

endpackage

// File: rtl/bnn_out_slot.sv
// Output holding register for packed activation words.
// A load always wins over a same-edge consume, so back-to-back words leave no bubble.
module bnn_out_slot
  import bnn_pkg::*;
#(
  parameter int WIDTH = BNN_WIDTH,
  parameter int LEN_W = BNN_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic [LEN_W-1:0] load_count,
  input  logic             out_ready,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic [LEN_W-1:0] out_count
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [LEN_W-1:0] count_q, count_d;

  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_count = count_q;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      word_d  = load_word;
      count_d = load_count;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bnn_act_packer.sv
// Packs 1-bit threshold activations LSB-first into words for the next layer.
// A completed word that cannot enter the output slot waits in the accumulator (pending).
module bnn_act_packer
  import bnn_pkg::*;
#(
  parameter int WIDTH       = BNN_WIDTH,
  parameter int LEN_W       = BNN_LEN_W,
  parameter int DEFAULT_LEN = BNN_DEFAULT_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             flush,
  input  logic             len_we,
  input  logic [LEN_W-1:0] len_in,
  output logic             len_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [LEN_W-1:0] out_count
);

  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] RESET_LEN = LEN_W'(DEFAULT_LEN);

  logic [WIDTH-1:0] acc_word_q, acc_word_d;
  logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [LEN_W-1:0] pack_len_q, pack_len_d;
  logic             pending_q, pending_d;
  logic             len_err_q, len_err_d;

  logic             accept;
  logic             complete;
  logic             slot_free;
  logic             load;
  logic [WIDTH-1:0] merged_word;
  logic [LEN_W-1:0] merged_cnt;

  assign in_ready = !pending_q;
  assign accept   = in_valid && !pending_q;
  assign len_err  = len_err_q;

  // Accumulator contents after this cycle's bit; flush is judged on this view.
  always_comb begin
    merged_word = acc_word_q;
    merged_cnt  = acc_cnt_q;
    if (accept) begin
      merged_word = acc_word_q | (WIDTH'(in_bit) << acc_cnt_q);
      merged_cnt  = acc_cnt_q + LEN_W'(1);
    end
  end

  assign complete = !pending_q &&
                    ((accept && (merged_cnt == pack_len_q)) ||
                     (flush && (merged_cnt != '0)));

  // While pending the accumulator is frozen, so merged_* equals the pending word.
  always_comb begin
    acc_word_d = merged_word;
    acc_cnt_d  = merged_cnt;
    pending_d  = pending_q;
    load       = 1'b0;
    if (pending_q) begin
      if (slot_free) begin
        load       = 1'b1;
        acc_word_d = '0;
        acc_cnt_d  = '0;
        pending_d  = 1'b0;
      end
    end else if (complete) begin
      if (slot_free) begin
        load       = 1'b1;
        acc_word_d = '0;
        acc_cnt_d  = '0;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    pack_len_d = pack_len_q;
    len_err_d  = 1'b0;
    if (len_we) begin
      if ((acc_cnt_q == '0) && !pending_q && !accept) begin
        pack_len_d = ((len_in == '0) || (len_in > FULL_LEN)) ? FULL_LEN : len_in;
      end else begin
        len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_word_q <= '0;
      acc_cnt_q  <= '0;
      pending_q  <= 1'b0;
      pack_len_q <= RESET_LEN;
      len_err_q  <= 1'b0;
    end else begin
      acc_word_q <= acc_word_d;
      acc_cnt_q  <= acc_cnt_d;
      pending_q  <= pending_d;
      pack_len_q <= pack_len_d;
      len_err_q  <= len_err_d;
    end
  end

  bnn_out_slot #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) u_out_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_word (merged_word),
    .load_count(merged_cnt),
    .out_ready (out_ready),
    .free      (slot_free),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_count (out_count)
  );

endmodule
